// File: rtl/branch_update_queue.sv
// branch_update_queue: in-order FIFO of branch predictions that emits a
// one-cycle chooser/predictor update when the oldest branch resolves.
module branch_update_queue #(
    parameter int IDX_W = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pred_valid_i,
    input  logic [IDX_W-1:0]         pred_idx_i,
    input  logic                     pred_p1_i,
    input  logic                     pred_p2_i,
    input  logic                     pred_choice_i,
    output logic                     pred_ready_o,
    input  logic                     res_valid_i,
    input  logic                     res_taken_i,
    input  logic                     flush_i,
    output logic                     upd_valid_o,
    output logic [IDX_W-1:0]         upd_idx_o,
    output logic                     upd_c1_o,
    output logic                     upd_c2_o,
    output logic                     upd_mispredict_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     err_underflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             p1;
        logic             p2;
        logic             ch;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           head;
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             enq, deq;
    logic             upd_valid_q, upd_valid_d;
    logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
    logic             upd_c1_q, upd_c1_d, upd_c2_q, upd_c2_d, upd_mis_q, upd_mis_d;
    logic             err_q, err_d;

    assign pred_ready_o = count_q != CW'(DEPTH);

    always_comb begin
        enq         = pred_valid_i && pred_ready_o && !flush_i;
        deq         = res_valid_i && count_q != '0;
        head        = mem_q[rd_q];
        // Flush wins over pointer advance; a same-cycle dequeue still reports below.
        wr_d        = flush_i ? '0 : wr_q + AW'(enq);
        rd_d        = flush_i ? '0 : rd_q + AW'(deq);
        count_d     = flush_i ? '0 : count_q + CW'(enq) - CW'(deq);
        upd_valid_d = deq;
        upd_idx_d   = deq ? head.idx : upd_idx_q;
        upd_c1_d    = deq ? head.p1 == res_taken_i : upd_c1_q;
        upd_c2_d    = deq ? head.p2 == res_taken_i : upd_c2_q;
        upd_mis_d   = deq ? (head.ch ? head.p2 : head.p1) != res_taken_i : upd_mis_q;
        err_d       = err_q | (res_valid_i && count_q == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q        <= '0;
            rd_q        <= '0;
            count_q     <= '0;
            upd_valid_q <= 1'b0;
            upd_idx_q   <= '0;
            upd_c1_q    <= 1'b0;
            upd_c2_q    <= 1'b0;
            upd_mis_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            count_q     <= count_d;
            upd_valid_q <= upd_valid_d;
            upd_idx_q   <= upd_idx_d;
            upd_c1_q    <= upd_c1_d;
            upd_c2_q    <= upd_c2_d;
            upd_mis_q   <= upd_mis_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) mem_q[wr_q] <= '{idx: pred_idx_i, p1: pred_p1_i, p2: pred_p2_i, ch: pred_choice_i};
    end

    assign upd_valid_o      = upd_valid_q;
    assign upd_idx_o        = upd_idx_q;
    assign upd_c1_o         = upd_c1_q;
    assign upd_c2_o         = upd_c2_q;
    assign upd_mispredict_o = upd_mis_q;
    assign count_o          = count_q;
    assign err_underflow_o  = err_q;
endmodule

// File: tb/tb_branch_update_queue.sv
// tb_branch_update_queue: directed vector table plus hand-written wrap and
// mid-operation reset sequences for branch_update_queue (DEPTH=4).
module tb_branch_update_queue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pv = 1'b0, p1 = 1'b0, p2 = 1'b0, ch = 1'b0, rv = 1'b0, tk = 1'b0, fl = 1'b0;
    logic [11:0] idx = '0;
    logic        rdy, uv, c1, c2, mis, err;
    logic [11:0] ui;
    logic [2:0]  cnt;
    int          errs = 0;
    int          checks = 0;

    typedef struct {
        logic pv; logic [11:0] idx; logic p1, p2, ch, rv, tk, fl;
        logic uv; logic [11:0] ui; logic c1, c2, mis; logic [2:0] cnt; logic rdy, err;
    } vec_t;

    vec_t tbl[$];

    branch_update_queue #(.IDX_W(12), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .pred_valid_i(pv), .pred_idx_i(idx), .pred_p1_i(p1), .pred_p2_i(p2),
        .pred_choice_i(ch), .pred_ready_o(rdy),
        .res_valid_i(rv), .res_taken_i(tk), .flush_i(fl),
        .upd_valid_o(uv), .upd_idx_o(ui), .upd_c1_o(c1), .upd_c2_o(c2),
        .upd_mispredict_o(mis), .count_o(cnt), .err_underflow_o(err)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input logic a_pv, input logic [11:0] a_idx, input logic a_p1, a_p2, a_ch,
                               input logic a_rv, a_tk, a_fl, input logic e_uv, input logic [11:0] e_ui,
                               input logic e_c1, e_c2, e_mis, input logic [2:0] e_cnt, input logic e_rdy, e_err);
        vec_t t;
        t.pv = a_pv; t.idx = a_idx; t.p1 = a_p1; t.p2 = a_p2; t.ch = a_ch;
        t.rv = a_rv; t.tk = a_tk; t.fl = a_fl;
        t.uv = e_uv; t.ui = e_ui; t.c1 = e_c1; t.c2 = e_c2; t.mis = e_mis;
        t.cnt = e_cnt; t.rdy = e_rdy; t.err = e_err;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic a_pv, input logic [11:0] a_idx, input logic a_p1, a_p2, a_ch,
                         input logic a_rv, a_tk, a_fl);
        pv = a_pv; idx = a_idx; p1 = a_p1; p2 = a_p2; ch = a_ch; rv = a_rv; tk = a_tk; fl = a_fl;
        @(posedge clk);
        #1;
        pv = 1'b0; rv = 1'b0; fl = 1'b0;
    endtask

    task automatic chk_all(input string tag, input logic e_uv, input logic [11:0] e_ui, input logic e_c1, e_c2,
                           e_mis, input logic [2:0] e_cnt, input logic e_rdy, e_err);
        chk({tag, ".upd_valid"}, 32'(uv), 32'(e_uv));
        chk({tag, ".upd_idx"}, 32'(ui), 32'(e_ui));
        chk({tag, ".upd_c1"}, 32'(c1), 32'(e_c1));
        chk({tag, ".upd_c2"}, 32'(c2), 32'(e_c2));
        chk({tag, ".upd_mis"}, 32'(mis), 32'(e_mis));
        chk({tag, ".count"}, 32'(cnt), 32'(e_cnt));
        chk({tag, ".ready"}, 32'(rdy), 32'(e_rdy));
        chk({tag, ".err"}, 32'(err), 32'(e_err));
    endtask

    initial begin
        // pv idx p1 p2 ch rv tk fl | uv ui c1 c2 mis cnt rdy err
        tbl.push_back(v(1, 12'h0A5, 0, 1, 0, 0, 0, 0, 0, 12'h000, 0, 0, 0, 1, 1, 0));
        tbl.push_back(v(0, 12'h000, 0, 0, 0, 1, 1, 0, 1, 12'h0A5, 0, 1, 1, 0, 1, 0));
        tbl.push_back(v(0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 12'h0A5, 0, 1, 1, 0, 1, 0));
        tbl.push_back(v(1, 12'h001, 1, 0, 1, 0, 0, 0, 0, 12'h0A5, 0, 1, 1, 1, 1, 0));
        tbl.push_back(v(1, 12'h002, 1, 1, 0, 0, 0, 0, 0, 12'h0A5, 0, 1, 1, 2, 1, 0));
        tbl.push_back(v(1, 12'h003, 0, 0, 1, 0, 0, 0, 0, 12'h0A5, 0, 1, 1, 3, 1, 0));
        tbl.push_back(v(1, 12'h004, 0, 1, 1, 0, 0, 0, 0, 12'h0A5, 0, 1, 1, 4, 0, 0));
        tbl.push_back(v(1, 12'h005, 1, 1, 1, 0, 0, 0, 0, 12'h0A5, 0, 1, 1, 4, 0, 0));
        tbl.push_back(v(0, 12'h000, 0, 0, 0, 1, 1, 0, 1, 12'h001, 1, 0, 1, 3, 1, 0));
        tbl.push_back(v(0, 12'h000, 0, 0, 0, 1, 0, 0, 1, 12'h002, 0, 0, 1, 2, 1, 0));
        tbl.push_back(v(0, 12'h000, 0, 0, 0, 1, 0, 0, 1, 12'h003, 1, 1, 0, 1, 1, 0));
        tbl.push_back(v(0, 12'h000, 0, 0, 0, 1, 1, 0, 1, 12'h004, 0, 1, 0, 0, 1, 0));
        tbl.push_back(v(0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 12'h004, 0, 1, 0, 0, 1, 0));
        tbl.push_back(v(1, 12'h010, 1, 0, 0, 0, 0, 0, 0, 12'h004, 0, 1, 0, 1, 1, 0));
        tbl.push_back(v(1, 12'h011, 0, 1, 1, 0, 0, 0, 0, 12'h004, 0, 1, 0, 2, 1, 0));
        tbl.push_back(v(1, 12'h012, 1, 1, 1, 1, 1, 0, 1, 12'h010, 1, 0, 0, 2, 1, 0));
        tbl.push_back(v(0, 12'h000, 0, 0, 0, 1, 0, 0, 1, 12'h011, 1, 0, 1, 1, 1, 0));
        tbl.push_back(v(0, 12'h000, 0, 0, 0, 1, 1, 0, 1, 12'h012, 1, 1, 0, 0, 1, 0));
        tbl.push_back(v(1, 12'h020, 1, 1, 0, 0, 0, 0, 0, 12'h012, 1, 1, 0, 1, 1, 0));
        tbl.push_back(v(1, 12'h021, 1, 1, 0, 0, 0, 0, 0, 12'h012, 1, 1, 0, 2, 1, 0));
        tbl.push_back(v(1, 12'h022, 1, 1, 0, 0, 0, 0, 0, 12'h012, 1, 1, 0, 3, 1, 0));
        tbl.push_back(v(1, 12'h023, 1, 1, 0, 0, 0, 0, 0, 12'h012, 1, 1, 0, 4, 0, 0));
        tbl.push_back(v(1, 12'h024, 1, 1, 0, 1, 1, 0, 1, 12'h020, 1, 1, 0, 3, 1, 0));
        tbl.push_back(v(0, 12'h000, 0, 0, 0, 1, 0, 0, 1, 12'h021, 0, 0, 1, 2, 1, 0));
        tbl.push_back(v(0, 12'h000, 0, 0, 0, 1, 0, 0, 1, 12'h022, 0, 0, 1, 1, 1, 0));
        tbl.push_back(v(0, 12'h000, 0, 0, 0, 1, 0, 0, 1, 12'h023, 0, 0, 1, 0, 1, 0));
        tbl.push_back(v(0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 12'h023, 0, 0, 1, 0, 1, 0));
        tbl.push_back(v(1, 12'h030, 0, 0, 0, 0, 0, 0, 0, 12'h023, 0, 0, 1, 1, 1, 0));
        tbl.push_back(v(1, 12'h031, 0, 0, 0, 0, 0, 0, 0, 12'h023, 0, 0, 1, 2, 1, 0));
        tbl.push_back(v(1, 12'h032, 0, 0, 0, 0, 0, 0, 0, 12'h023, 0, 0, 1, 3, 1, 0));
        tbl.push_back(v(1, 12'h033, 1, 1, 1, 1, 0, 1, 1, 12'h030, 1, 1, 0, 0, 1, 0));
        tbl.push_back(v(0, 12'h000, 0, 0, 0, 1, 1, 0, 0, 12'h030, 1, 1, 0, 0, 1, 1));
        tbl.push_back(v(1, 12'h040, 1, 1, 0, 1, 1, 0, 0, 12'h030, 1, 1, 0, 1, 1, 1));
        tbl.push_back(v(0, 12'h000, 0, 0, 0, 1, 1, 0, 1, 12'h040, 1, 1, 0, 0, 1, 1));

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 1, 0);
        chk_all("reset", 0, 12'h000, 0, 0, 0, 0, 1, 0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].pv, tbl[i].idx, tbl[i].p1, tbl[i].p2, tbl[i].ch, tbl[i].rv, tbl[i].tk, tbl[i].fl);
            chk_all($sformatf("v%0d", i), tbl[i].uv, tbl[i].ui, tbl[i].c1, tbl[i].c2, tbl[i].mis,
                    tbl[i].cnt, tbl[i].rdy, tbl[i].err);
        end

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) begin
                drive(1, 12'(12'h050 + r * 4 + k), k[0], ~k[0], k[1], 0, 0, 0);
                chk($sformatf("wrap%0d.fill%0d.count", r, k), 32'(cnt), 32'(k + 1));
            end
            for (int k = 0; k < 4; k++) begin
                logic ep1, ep2, sel;
                ep1 = k[0];
                ep2 = ~k[0];
                sel = k[1] ? ep2 : ep1;
                drive(0, 0, 0, 0, 0, 1, 1, 0);
                chk_all($sformatf("wrap%0d.drain%0d", r, k), 1, 12'(12'h050 + r * 4 + k),
                        ep1, ep2, ~sel, 3'(3 - k), 1, 1);
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("wrap.idle.upd_valid", 32'(uv), 32'(0));

        drive(1, 12'h060, 1, 0, 0, 0, 0, 0);
        drive(1, 12'h061, 0, 1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 1, 0);
        chk_all("midrst.pre", 1, 12'h060, 1, 0, 0, 1, 1, 1);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 1, 1, 0);
        chk_all("midrst.in", 0, 12'h000, 0, 0, 0, 0, 1, 0);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 1, 1, 0);
        chk_all("midrst.post", 0, 12'h000, 0, 0, 0, 0, 1, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
